// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns the fetch stage's PC into one outstanding SRAM-like bus read.
// Latency: pc_valid in cycle 0, addr_ok 1, data_ok 2 -> if_inst_valid in cycle 3 on a zero-wait bus.
// Backpressure: if_stall parks a returned word in a one-entry hold buffer; flush cancels in-flight reads.
// Optional counters are built only when INST_FETCH_PERF_EN is defined.
module inst_fetch_bridge #(
  parameter logic [31:0] FETCH_ADDR_MASK = 32'h1fff_ffff,
  parameter logic [31:0] NOP_INST        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  input  logic        if_stall,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic [31:0] if_inst,
  output logic        if_inst_valid,
  output logic        delay_hard,
  output logic        IADEE,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_HOLD   = 3'd3,
    S_CANCEL = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        req_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] inst_nxt;
  logic        valid_nxt;
  logic        adee_nxt;
  logic [31:0] hold_buf, hold_buf_nxt;
  logic        hold_vld, hold_vld_nxt;
  logic        cancel_flag, cancel_nxt;

  // Next-state and next-register values; if_inst/valid/IADEE default to a NOP bubble each cycle.
  always_comb begin
    state_nxt    = state;
    req_nxt      = inst_req;
    addr_nxt     = inst_addr;
    inst_nxt     = NOP_INST;
    valid_nxt    = 1'b0;
    adee_nxt     = 1'b0;
    hold_buf_nxt = hold_buf;
    hold_vld_nxt = hold_vld;
    cancel_nxt   = cancel_flag;
    case (state)
      S_IDLE: begin
        if (pc_valid) begin
          if (pc[1:0] != 2'b00) begin
            // Misaligned PC never touches the bus; report it with a NOP.
            valid_nxt = 1'b1;
            adee_nxt  = 1'b1;
          end else if (!flush) begin
            addr_nxt  = pc & FETCH_ADDR_MASK;
            req_nxt   = 1'b1;
            state_nxt = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (inst_addr_ok) begin
          req_nxt   = 1'b0;
          state_nxt = (flush || cancel_flag) ? S_CANCEL : S_DATA;
        end else if (flush) begin
          // Address still pending: remember the kill so the response is dropped later.
          cancel_nxt = 1'b1;
        end
      end
      S_DATA: begin
        if (inst_data_ok) begin
          if (flush) begin
            state_nxt = S_IDLE;
          end else if (if_stall) begin
            hold_buf_nxt = inst_rdata;
            hold_vld_nxt = 1'b1;
            state_nxt    = S_HOLD;
          end else begin
            inst_nxt  = inst_rdata;
            valid_nxt = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (flush) begin
          state_nxt = S_CANCEL;
        end
      end
      S_HOLD: begin
        if (flush) begin
          hold_vld_nxt = 1'b0;
          state_nxt    = S_IDLE;
        end else if (!if_stall) begin
          inst_nxt     = hold_buf;
          valid_nxt    = hold_vld;
          hold_vld_nxt = 1'b0;
          state_nxt    = S_IDLE;
        end
      end
      S_CANCEL: begin
        if (inst_data_ok) begin
          cancel_nxt = 1'b0;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      inst_req      <= 1'b0;
      inst_addr     <= 32'h0;
      if_inst       <= NOP_INST;
      if_inst_valid <= 1'b0;
      IADEE         <= 1'b0;
      hold_buf      <= 32'h0;
      hold_vld      <= 1'b0;
      cancel_flag   <= 1'b0;
    end else begin
      state         <= state_nxt;
      inst_req      <= req_nxt;
      inst_addr     <= addr_nxt;
      if_inst       <= inst_nxt;
      if_inst_valid <= valid_nxt;
      IADEE         <= adee_nxt;
      hold_buf      <= hold_buf_nxt;
      hold_vld      <= hold_vld_nxt;
      cancel_flag   <= cancel_nxt;
    end
  end

  // Freeze the fetch stage while a word is owed; never in HOLD or while a word is being presented.
  always_comb begin
    delay_hard = 1'b0;
    if (!if_inst_valid) begin
      if (state == S_ADDR || state == S_DATA || state == S_CANCEL)
        delay_hard = 1'b1;
      else if (state == S_IDLE && pc_valid && !flush)
        delay_hard = 1'b1;
    end
  end

`ifdef INST_FETCH_PERF_EN
  // Count delivered real instructions and frozen cycles; both wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (if_inst_valid && !IADEE)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (delay_hard)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge with a scoreboard of expected delivered words.
// Bench drives the bus handshake by hand; inputs change 1ns after the rising edge.
// Counter checks follow INST_FETCH_PERF_EN (expected 0 when the feature is not built).
module tb_inst_fetch_bridge;

  localparam logic [31:0] MASK = 32'h1fff_ffff;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        pc_valid = 1'b0;
  logic        if_stall = 1'b0;
  logic        flush = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] if_inst;
  logic        if_inst_valid;
  logic        delay_hard;
  logic        IADEE;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];   // {iadee, word}

  inst_fetch_bridge dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .if_stall(if_stall),
    .flush(flush), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .if_inst(if_inst), .if_inst_valid(if_inst_valid), .delay_hard(delay_hard),
    .IADEE(IADEE), .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid pulse must match the oldest expectation; idle cycles must show a NOP.
  always @(negedge clk) begin
    logic [32:0] e;
    if (if_inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_word", if_inst, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        chk("sb_word", if_inst, e[31:0]);
        chk("sb_iadee", {31'h0, IADEE}, {31'h0, e[32]});
      end
    end else begin
      chk("idle_nop", if_inst, NOP);
      chk("idle_iadee", {31'h0, IADEE}, 32'h0);
    end
  end

  // Clean zero-wait fetch; returns 1ns after the edge following the delivery cycle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    pc = a; pc_valid = 1'b1;
    exp_q.push_back({1'b0, d});
    @(negedge clk); chk("f0_delay", delay_hard, 1);
    tick(); pc_valid = 1'b0; inst_addr_ok = 1'b1;
    @(negedge clk); chk("f1_req", inst_req, 1); chk("f1_addr", inst_addr, a & MASK);
    chk("f1_delay", delay_hard, 1);
    tick(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = d;
    @(negedge clk); chk("f2_req", inst_req, 0); chk("f2_delay", delay_hard, 1);
    tick(); inst_data_ok = 1'b0;
    @(negedge clk); chk("f3_valid", if_inst_valid, 1); chk("f3_delay", delay_hard, 0);
    tick();
  endtask

  initial begin
    logic [31:0] exp_perf;
    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_req", inst_req, 0); chk("rst_addr", inst_addr, 0);
    chk("rst_inst", if_inst, NOP); chk("rst_valid", if_inst_valid, 0);
    chk("rst_delay", delay_hard, 0); chk("rst_iadee", IADEE, 0);
    tick(); tick(); reset = 1'b0;

    // 1: plain fetch, latency and address masking
    fetch(32'hbfc0_0000, 32'h2408_0001);

    // 2: stall over data_ok for three cycles
    pc = 32'hbfc0_0000; pc_valid = 1'b1; exp_q.push_back({1'b0, 32'h8fbf_0010});
    tick(); pc_valid = 1'b0; inst_addr_ok = 1'b1;
    tick(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8fbf_0010; if_stall = 1'b1;
    tick(); inst_data_ok = 1'b0;
    @(negedge clk); chk("hold_delay", delay_hard, 0); chk("hold_req", inst_req, 0);
    chk("hold_valid", if_inst_valid, 0);
    tick();
    tick(); if_stall = 1'b0;
    @(negedge clk); chk("unstall_valid_early", if_inst_valid, 0);
    tick();
    @(negedge clk); chk("unstall_valid", if_inst_valid, 1); chk("unstall_delay", delay_hard, 0);
    tick();
    @(negedge clk); chk("after_hold_valid", if_inst_valid, 0); chk("after_hold_req", inst_req, 0);
    tick();

    // 3: flush in DATA, response two cycles later is discarded
    pc = 32'hbfc0_0004; pc_valid = 1'b1;
    tick(); pc_valid = 1'b0; inst_addr_ok = 1'b1;
    tick(); inst_addr_ok = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0; pc = 32'hbfc0_0008; pc_valid = 1'b1;
    @(negedge clk); chk("cancel_delay", delay_hard, 1); chk("cancel_req", inst_req, 0);
    tick(); inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
    @(negedge clk); chk("cancel_req2", inst_req, 0);
    tick(); inst_data_ok = 1'b0; exp_q.push_back({1'b0, 32'h0000_0013});
    @(negedge clk); chk("post_cancel_req", inst_req, 0); chk("post_cancel_valid", if_inst_valid, 0);
    tick(); pc_valid = 1'b0; inst_addr_ok = 1'b1;
    @(negedge clk); chk("refetch_req", inst_req, 1); chk("refetch_addr", inst_addr, 32'h1fc0_0008);
    tick(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0000_0013;
    tick(); inst_data_ok = 1'b0;
    @(negedge clk); chk("refetch_valid", if_inst_valid, 1);
    tick();

    // 4: flush coincident with data_ok
    pc = 32'hbfc0_000c; pc_valid = 1'b1;
    tick(); pc_valid = 1'b0; inst_addr_ok = 1'b1;
    tick(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hcafe_0000; flush = 1'b1;
    tick(); inst_data_ok = 1'b0; flush = 1'b0; pc = 32'hbfc0_0010; pc_valid = 1'b1;
    exp_q.push_back({1'b0, 32'h1111_2222});
    @(negedge clk); chk("fd_valid", if_inst_valid, 0); chk("fd_delay", delay_hard, 1);
    chk("fd_req", inst_req, 0);
    tick(); pc_valid = 1'b0; inst_addr_ok = 1'b1;
    @(negedge clk); chk("fd_idle_req", inst_req, 1); chk("fd_addr", inst_addr, 32'h1fc0_0010);
    tick(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222;
    tick(); inst_data_ok = 1'b0;
    @(negedge clk); chk("fd_next_valid", if_inst_valid, 1);
    tick();

    // 5: misaligned PC
    pc = 32'hbfc0_0002; pc_valid = 1'b1; exp_q.push_back({1'b1, NOP});
    tick(); pc_valid = 1'b0;
    @(negedge clk); chk("ade_req", inst_req, 0); chk("ade_valid", if_inst_valid, 1);
    chk("ade_flag", IADEE, 1); chk("ade_inst", if_inst, NOP);
    tick();
    @(negedge clk); chk("ade_once", IADEE, 0); chk("ade_valid_once", if_inst_valid, 0);
    tick();

`ifdef INST_FETCH_PERF_EN
    exp_perf = 32'd4;
`else
    exp_perf = 32'd0;
`endif
    #1 chk("perf_fetch_4", perf_fetch_cnt, exp_perf);

    // 6: reset while in DATA, then two clean fetches
    tick();
    pc = 32'hbfc0_0020; pc_valid = 1'b1; exp_q.push_back({1'b0, 32'h0});
    tick(); pc_valid = 1'b0; inst_addr_ok = 1'b1;
    tick(); inst_addr_ok = 1'b0; reset = 1'b1;
    #1;
    chk("mid_rst_req", inst_req, 0); chk("mid_rst_addr", inst_addr, 0);
    chk("mid_rst_inst", if_inst, NOP); chk("mid_rst_valid", if_inst_valid, 0);
    chk("mid_rst_delay", delay_hard, 0); chk("mid_rst_iadee", IADEE, 0);
    chk("mid_rst_pf", perf_fetch_cnt, 0); chk("mid_rst_ps", perf_stall_cnt, 0);
    exp_q.delete();
    tick(); reset = 1'b0;
    fetch(32'hbfc0_0100, 32'h0000_0021);
    fetch(32'hbfc0_0104, 32'h0000_0022);
`ifdef INST_FETCH_PERF_EN
    exp_perf = 32'd2;
`else
    exp_perf = 32'd0;
`endif
    #1 chk("perf_fetch_2", perf_fetch_cnt, exp_perf);
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
